// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// Port 0 is the CPU load/store path and port 1 is a secondary master
// (loader / debug DMA). Ownership is round-robin, and each tenure is bounded
// by MAX_HOLD cycles while the other port waits, so neither master starves.
// Read data is registered per port and qualified by a one-cycle valid strobe.
//
// Request/grant handshake: reqN is a level that the master holds, together
// with wrN/addrN/wdataN, until it sees gntN. gntN comes from a register, so
// the earliest access is the cycle after req rises from idle. Every cycle in
// which gntN and reqN are both high performs exactly one memory access. A
// read performed in cycle t returns rdataN with rvalidN high in cycle t+1.
// A write produces no rvalid.
module dmem_arbiter #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int MAX_HOLD       = 4,
    parameter int HOLD_BITS      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0,
    input  logic                      wr0,
    input  logic [DATA_BIT_WIDTH-1:0] addr0,
    input  logic [DATA_BIT_WIDTH-1:0] wdata0,
    output logic                      gnt0,
    output logic                      rvalid0,
    output logic [DATA_BIT_WIDTH-1:0] rdata0,
    input  logic                      req1,
    input  logic                      wr1,
    input  logic [DATA_BIT_WIDTH-1:0] addr1,
    input  logic [DATA_BIT_WIDTH-1:0] wdata1,
    output logic                      gnt1,
    output logic                      rvalid1,
    output logic [DATA_BIT_WIDTH-1:0] rdata1,
    output logic                      memWr,
    output logic [DATA_BIT_WIDTH-1:0] memAddr,
    output logic [DATA_BIT_WIDTH-1:0] memDin,
    input  logic [DATA_BIT_WIDTH-1:0] memDout,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Last tenure count at which a contended owner must hand over.
    localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(MAX_HOLD - 1);

    state_t                      state_q, state_d;
    logic [HOLD_BITS-1:0]        hold_q, hold_d;
    logic                        last_q, last_d;
    logic                        rvalid0_q, rvalid1_q;
    logic [DATA_BIT_WIDTH-1:0]   rdata0_q, rdata1_q;
    logic                        acc0, acc1;

    // A port accesses memory only when it owns the bus and still requests;
    // reset suppresses any access in the cycle it is asserted.
    assign acc0 = (state_q == ST_OWN0) && req0 && !reset;
    assign acc1 = (state_q == ST_OWN1) && req1 && !reset;

    assign gnt0      = (state_q == ST_OWN0);
    assign gnt1      = (state_q == ST_OWN1);
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign dbg_state = state_q;

    // Memory port mux: the accessing port drives the memory, otherwise all zero.
    always_comb begin
        memWr   = 1'b0;
        memAddr = '0;
        memDin  = '0;
        if (acc0) begin
            memWr   = wr0;
            memAddr = addr0;
            memDin  = wdata0;
        end else if (acc1) begin
            memWr   = wr1;
            memAddr = addr1;
            memDin  = wdata1;
        end
    end

    // Next-state logic: round-robin entry from idle, bounded tenure when contended.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = ST_OWN0;
                    hold_d  = '0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                    hold_d  = '0;
                    last_d  = 1'b1;
                end
            end
            ST_OWN0: begin
                if (req0 && (!req1 || (hold_q < HOLD_LAST))) begin
                    // Stay; the counter saturates while the other port is quiet.
                    if (hold_q < HOLD_LAST) begin
                        hold_d = hold_q + HOLD_BITS'(1);
                    end
                end else if (req1) begin
                    state_d = ST_OWN1;
                    hold_d  = '0;
                    last_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (req1 && (!req0 || (hold_q < HOLD_LAST))) begin
                    if (hold_q < HOLD_LAST) begin
                        hold_d = hold_q + HOLD_BITS'(1);
                    end
                end else if (req0) begin
                    state_d = ST_OWN0;
                    hold_d  = '0;
                    last_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; port 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    // Per-port read return: capture memory data at the end of a read access.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= acc0 && !wr0;
            rvalid1_q <= acc1 && !wr1;
            if (acc0 && !wr0) begin
                rdata0_q <= memDout;
            end
            if (acc1 && !wr1) begin
                rdata1_q <= memDout;
            end
        end
    end

endmodule
